// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline controller: combinational stall vector, flush sequencing with
// redirect PC, and a stall watchdog that freezes the pipe until the next flush.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_LIMIT  = 16,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [CNT_W-1:0] FCNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(STALL_LIMIT > 0 ? STALL_LIMIT - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             flush_q, flush_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic             timeout_q, timeout_d;

    // Furthest-downstream requester wins: stalling a stage also holds everything upstream.
    always_comb begin
        stall = 6'b000000;
        if (!rst) begin
            case (state_q)
                S_RUN: begin
                    if (stallreq_mem)      stall = 6'b011111;
                    else if (stallreq_ex)  stall = 6'b001111;
                    else if (stallreq_id)  stall = 6'b000111;
                    else if (stallreq_if)  stall = 6'b000011;
                    else                   stall = 6'b000000;
                end
                S_HALT:  stall = 6'b111111;
                default: stall = 6'b000000;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        fcnt_d    = fcnt_q;
        flush_d   = flush_q;
        new_pc_d  = new_pc_q;
        timeout_d = timeout_q;
        if (flush_req) begin
            // A flush overrides everything, including a simultaneous watchdog trip.
            state_d   = S_FLUSH;
            flush_d   = 1'b1;
            new_pc_d  = flush_pc;
            fcnt_d    = FCNT_INIT;
            timeout_d = 1'b0;
            scnt_d    = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stall != 6'b000000) begin
                        if (STALL_LIMIT > 0 && scnt_q == LIMIT_M1) begin
                            state_d   = S_HALT;
                            timeout_d = 1'b1;
                            scnt_d    = '0;
                        end else begin
                            scnt_d = scnt_q + CNT_W'(1);
                        end
                    end else begin
                        scnt_d = '0;
                    end
                end
                S_FLUSH: begin
                    if (fcnt_q != '0) begin
                        fcnt_d = fcnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_RUN;
                        flush_d = 1'b0;
                    end
                end
                S_HALT: begin
                end
                default: begin
                    state_d = S_RUN;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RUN;
            scnt_q    <= '0;
            fcnt_q    <= '0;
            flush_q   <= 1'b0;
            new_pc_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            fcnt_q    <= fcnt_d;
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
            timeout_q <= timeout_d;
        end
    end

    assign flush         = flush_q;
    assign new_pc        = new_pc_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: dut_a uses FLUSH_CYCLES=1, dut_b uses FLUSH_CYCLES=3.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  a_req = 4'b0000;  // {mem,ex,id,if}
    logic        a_fr = 1'b0;
    logic [31:0] a_pc = 32'h0;
    logic [3:0]  b_req = 4'b0000;
    logic        b_fr = 1'b0;
    logic [31:0] b_pc = 32'h0;
    logic [5:0]  a_stall, b_stall;
    logic        a_flush, b_flush, a_to, b_to;
    logic [31:0] a_new_pc, b_new_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.FLUSH_CYCLES(1), .STALL_LIMIT(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .stallreq_if(a_req[0]), .stallreq_id(a_req[1]),
        .stallreq_ex(a_req[2]), .stallreq_mem(a_req[3]),
        .flush_req(a_fr), .flush_pc(a_pc),
        .stall(a_stall), .flush(a_flush), .new_pc(a_new_pc), .stall_timeout(a_to)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(3), .STALL_LIMIT(16), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .stallreq_if(b_req[0]), .stallreq_id(b_req[1]),
        .stallreq_ex(b_req[2]), .stallreq_mem(b_req[3]),
        .flush_req(b_fr), .flush_pc(b_pc),
        .stall(b_stall), .flush(b_flush), .new_pc(b_new_pc), .stall_timeout(b_to)
    );

    typedef struct {
        string       tag;
        bit          sel;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        to;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the selected DUT and queue the outputs expected in that cycle.
    task automatic step(input bit sel, input logic [3:0] req, input logic fr, input logic [31:0] pc,
                        input logic [5:0] es, input logic ef, input logic [31:0] epc,
                        input logic eto, input string tag);
        exp_t e;
        @(negedge clk);
        if (sel) begin
            b_req = req; b_fr = fr; b_pc = pc;
        end else begin
            a_req = req; a_fr = fr; a_pc = pc;
        end
        e.tag = tag; e.sel = sel; e.stall = es; e.flush = ef; e.pc = epc; e.to = eto;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    $display("txn b %-12s stall=%b flush=%b new_pc=%h to=%b",
                             e.tag, b_stall, b_flush, b_new_pc, b_to);
                    check_eq({e.tag, "_stall"}, 32'(b_stall), 32'(e.stall));
                    check_eq({e.tag, "_flush"}, 32'(b_flush), 32'(e.flush));
                    check_eq({e.tag, "_pc"}, b_new_pc, e.pc);
                    check_eq({e.tag, "_to"}, 32'(b_to), 32'(e.to));
                end else begin
                    $display("txn a %-12s stall=%b flush=%b new_pc=%h to=%b",
                             e.tag, a_stall, a_flush, a_new_pc, a_to);
                    check_eq({e.tag, "_stall"}, 32'(a_stall), 32'(e.stall));
                    check_eq({e.tag, "_flush"}, 32'(a_flush), 32'(e.flush));
                    check_eq({e.tag, "_pc"}, a_new_pc, e.pc);
                    check_eq({e.tag, "_to"}, 32'(a_to), 32'(e.to));
                end
            end
        end
    end

    localparam logic [3:0] R_NONE = 4'b0000;
    localparam logic [3:0] R_EX   = 4'b0100;
    localparam logic [3:0] R_MEM  = 4'b1000;

    initial begin
        // Reset: stall must be forced to zero even with requests present.
        a_req = R_MEM;
        b_req = R_EX;
        #1 rst = 1'b1;
        #2;
        check_eq("rst_a_stall", 32'(a_stall), 32'h0);
        check_eq("rst_b_stall", 32'(b_stall), 32'h0);
        check_eq("rst_a_flush", 32'(a_flush), 32'h0);
        check_eq("rst_a_pc", a_new_pc, 32'h0);
        check_eq("rst_a_to", 32'(a_to), 32'h0);
        @(negedge clk);
        rst = 1'b0; a_req = R_NONE; b_req = R_NONE;

        // Priority encoding.
        step(0, 4'b1010, 0, 0, 6'b011111, 0, 32'h0, 0, "t1_id_mem");
        step(0, R_NONE,  0, 0, 6'b000000, 0, 32'h0, 0, "t1_release");
        step(0, 4'b0001, 0, 0, 6'b000011, 0, 32'h0, 0, "t1_if");
        step(0, 4'b0011, 0, 0, 6'b000111, 0, 32'h0, 0, "t1_id_if");
        step(0, 4'b0101, 0, 0, 6'b001111, 0, 32'h0, 0, "t1_ex_if");
        step(0, R_NONE,  0, 0, 6'b000000, 0, 32'h0, 0, "t1_idle");

        // Three-cycle ex pulse; release must clear the stall counter.
        for (int i = 0; i < 3; i++)
            step(0, R_EX, 0, 0, 6'b001111, 0, 32'h0, 0, $sformatf("t2_ex%0d", i));
        step(0, R_NONE, 0, 0, 6'b000000, 0, 32'h0, 0, "t2_release");

        // Watchdog: 16 stalled cycles then HALT; flush exits HALT.
        for (int i = 0; i < 16; i++)
            step(0, R_EX, 0, 0, 6'b001111, 0, 32'h0, 0, $sformatf("t4_c%0d", i));
        step(0, R_EX, 0, 0, 6'b111111, 0, 32'h0, 1, "t4_c16");
        step(0, R_EX, 0, 0, 6'b111111, 0, 32'h0, 1, "t4_c17");
        step(0, R_EX, 1, 32'h300, 6'b111111, 0, 32'h0, 1, "t4_freq");
        step(0, R_EX, 0, 0, 6'b000000, 1, 32'h300, 0, "t4_flush");
        step(0, R_EX, 0, 0, 6'b001111, 0, 32'h300, 0, "t4_run");
        step(0, R_NONE, 0, 0, 6'b000000, 0, 32'h300, 0, "t4_idle");

        // Single-cycle flush; requests during FLUSH are ignored.
        step(0, R_NONE, 1, 32'h180, 6'b000000, 0, 32'h300, 0, "t3_req");
        step(0, R_EX,   0, 0, 6'b000000, 1, 32'h180, 0, "t3_flush");
        step(0, R_NONE, 0, 0, 6'b000000, 0, 32'h180, 0, "t3_done");

        // Flush and stall request in the same RUN cycle.
        step(0, R_MEM, 1, 32'h1c0, 6'b011111, 0, 32'h180, 0, "sim_req");
        step(0, R_MEM, 0, 0, 6'b000000, 1, 32'h1c0, 0, "sim_flush");
        step(0, R_MEM, 0, 0, 6'b011111, 0, 32'h1c0, 0, "sim_run");
        step(0, R_NONE, 0, 0, 6'b000000, 0, 32'h1c0, 0, "sim_idle");

        // Flush on the HALT-entry edge wins and leaves the timeout clear.
        for (int i = 0; i < 16; i++)
            step(0, R_EX, (i == 15), 32'h2c0, 6'b001111, 0, 32'h1c0, 0, $sformatf("he_c%0d", i));
        step(0, R_EX, 0, 0, 6'b000000, 1, 32'h2c0, 0, "he_flush");
        step(0, R_NONE, 0, 0, 6'b000000, 0, 32'h2c0, 0, "he_run");

        // Three-cycle flush restarted by a second request in flush cycle 2.
        step(1, R_NONE, 1, 32'h100, 6'b000000, 0, 32'h0, 0, "t5_req1");
        step(1, R_NONE, 0, 0, 6'b000000, 1, 32'h100, 0, "t5_f1");
        step(1, R_NONE, 1, 32'h200, 6'b000000, 1, 32'h100, 0, "t5_f2_req2");
        step(1, R_NONE, 0, 0, 6'b000000, 1, 32'h200, 0, "t5_r1");
        step(1, R_NONE, 0, 0, 6'b000000, 1, 32'h200, 0, "t5_r2");
        step(1, R_NONE, 0, 0, 6'b000000, 1, 32'h200, 0, "t5_r3");
        step(1, R_NONE, 0, 0, 6'b000000, 0, 32'h200, 0, "t5_done");

        // dut_a into HALT while dut_b enters FLUSH, then async reset between clock edges.
        for (int i = 0; i < 16; i++) begin
            step(0, R_EX, 0, 0, 6'b001111, 0, 32'h2c0, 0, $sformatf("t6_c%0d", i));
            if (i == 15) begin
                b_fr = 1'b1; b_pc = 32'h240;
            end
        end
        step(0, R_EX, 0, 0, 6'b111111, 0, 32'h2c0, 1, "t6_halt");
        b_fr = 1'b0;
        #2;
        check_eq("t6_b_inflush", 32'(b_flush), 32'h1);
        #1 rst = 1'b1;
        #1;
        check_eq("t6_a_stall", 32'(a_stall), 32'h0);
        check_eq("t6_a_to", 32'(a_to), 32'h0);
        check_eq("t6_a_pc", a_new_pc, 32'h0);
        check_eq("t6_b_flush", 32'(b_flush), 32'h0);
        check_eq("t6_b_pc", b_new_pc, 32'h0);
        check_eq("t6_b_stall", 32'(b_stall), 32'h0);
        @(negedge clk);
        rst = 1'b0; a_req = R_NONE; b_req = R_NONE;
        step(0, R_NONE, 0, 0, 6'b000000, 0, 32'h0, 0, "post_rst");
        step(0, 4'b0010, 0, 0, 6'b000111, 0, 32'h0, 0, "post_id");

        @(negedge clk);
        #5;
        check_eq("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
